// File: rtl/ctx_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ctx_stack
//  Description : Hardware context stack for the single-cycle CPU. Holds
//                subroutine return addresses and, for interrupt entries,
//                the return address plus the saved flag word. Supports
//                replace-top on simultaneous push/pop, an occupancy count
//                and sticky, clearable overflow/underflow flags.
//  Revision    : 1.0  - initial release
// ============================================================================
module ctx_stack #(
    parameter int AW    = 10,
    parameter int FW    = 2,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          push_int,
    input  logic          pop,
    input  logic          clr_err,
    input  logic [AW-1:0] pc_in,
    input  logic [FW-1:0] flags_in,
    output logic [AW-1:0] top_pc,
    output logic [FW-1:0] top_flags,
    output logic          top_is_int,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf
);

    // Index width into the entry array and width of one stored frame
    // ({tag, flags, pc}).
    localparam int c_IW = $clog2(DEPTH);
    localparam int c_DW = AW + FW + 1;

    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] c_CNT_FULL = CW'(DEPTH);

    // Entry storage; deliberately not reset, the empty gating hides stale data.
    logic [c_DW-1:0] r_mem [DEPTH];

    logic [CW-1:0]   r_count;
    logic            r_ovf;
    logic            r_unf;

    logic            w_empty;
    logic            w_full;
    logic            w_wr;
    logic [c_DW-1:0] w_data;
    logic [c_IW-1:0] w_top_idx;
    logic [c_IW-1:0] w_wr_idx;
    logic [c_DW-1:0] w_top_entry;
    logic            w_do_write;
    logic            w_inc;
    logic            w_dec;
    logic            w_ovf_set;
    logic            w_unf_set;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_CNT_FULL);
    assign w_wr      = push | push_int;
    // Top entry sits at sp-1; the value is meaningless when empty but gated.
    assign w_top_idx = c_IW'(r_count - c_CNT_ONE);

    // Frame to store: interrupt frames carry flags and tag, call frames zero both.
    always_comb begin
        w_data = {1'b0, {FW{1'b0}}, pc_in};
        if (push_int) begin
            w_data = {1'b1, flags_in, pc_in};
        end
    end

    // Decode the per-cycle action from (write, pop, occupancy).
    always_comb begin
        w_do_write = 1'b0;
        w_wr_idx   = c_IW'(r_count);
        w_inc      = 1'b0;
        w_dec      = 1'b0;
        w_ovf_set  = 1'b0;
        w_unf_set  = 1'b0;
        case ({w_wr, pop})
            2'b10: begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_do_write = 1'b1;
                    w_inc      = 1'b1;
                end
            end
            2'b01: begin
                if (w_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            2'b11: begin
                if (w_empty) begin
                    // Nothing to pop: behaves as a plain push but flags underflow.
                    w_do_write = 1'b1;
                    w_inc      = 1'b1;
                    w_unf_set  = 1'b1;
                end else begin
                    // Replace top in place; never an overflow, even when full.
                    w_do_write = 1'b1;
                    w_wr_idx   = w_top_idx;
                end
            end
            default: begin
            end
        endcase
    end

    // Entry array write; suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset && w_do_write) begin
            r_mem[w_wr_idx] <= w_data;
        end
    end

    // Occupancy counter and sticky error flags; a new error beats clr_err.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_inc) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_dec) begin
                r_count <= r_count - c_CNT_ONE;
            end
            r_ovf <= w_ovf_set | (r_ovf & ~clr_err);
            r_unf <= w_unf_set | (r_unf & ~clr_err);
        end
    end

    assign w_top_entry = r_mem[w_top_idx];

    assign top_pc     = w_empty ? '0   : w_top_entry[AW-1:0];
    assign top_flags  = w_empty ? '0   : w_top_entry[AW+FW-1:AW];
    assign top_is_int = w_empty ? 1'b0 : w_top_entry[c_DW-1];
    assign count      = r_count;
    assign empty      = w_empty;
    assign full       = w_full;
    assign ovf        = r_ovf;
    assign unf        = r_unf;

endmodule
`default_nettype wire

// File: doc/ctx_stack.md
# ctx_stack

Parametrised hardware context stack for the single-cycle CPU datapath. It holds return addresses for subroutine calls and, for interrupt entries, the return address together with the flag word (Z, C, …), so that a return restores both. It generalises the fixed 10-bit call stack with these additions:
- configurable PC width, flag width and depth
- tagged interrupt frames
- replace-top on simultaneous push/pop
- an occupancy count
- sticky, clearable overflow/underflow flags

## Interface
Parameters:
- AW, 10, width of stored program-counter value
- FW, 2, width of stored flag word (bit 0 = Z, bit 1 = C in the default CPU)
- DEPTH, 16, number of entries; any integer ≥ 2
- CW, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock; sole clock domain
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
- push  in  1  push a call frame: pc_in stored, flags stored as 0, tag = 0
- push_int  in  1  push an interrupt frame: pc_in and flags_in stored, tag = 1; has priority over push
- pop  in  1  remove top frame
- clr_err  in  1  clear sticky ovf/unf
- pc_in  in  AW  return address to save
- flags_in  in  FW  flag word to save on push_int
- top_pc  out  AW  PC field of top entry; 0 when empty
- top_flags  out  FW  flag field of top entry; 0 when empty
- top_is_int  out  1  tag of top entry; 0 when empty
- count  out  CW  number of valid entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- ovf  out  1  sticky: push attempted while full
- unf  out  1  sticky: pop attempted while empty

## Operation
Storage and derived outputs:
- Storage: DEPTH × (AW+FW+1) register array, plus stack pointer sp = count. The top entry is index sp−1.
- top_* outputs are combinational from entry sp−1, gated to 0 when empty.
- empty and full are combinational from count.

Effective push: wr = push | push_int. Data written = {tag, flags, pc}:
- push_int: tag = 1, flags = flags_in
- push only: tag = 0, flags = 0

Per-cycle action, selected on (wr, pop, state):
- wr only, not full: entry[sp] ← data; count+1.
- wr only, full: no write; count unchanged; ovf ← 1.
- pop only, not empty: count−1. The entry contents are left as is.
- pop only, empty: no change; unf ← 1.
- wr and pop, not empty: replace top. entry[sp−1] ← data; count unchanged; no ovf, including when full.
- wr and pop, empty: acts as a plain push; count 1; unf ← 1.
- Neither: hold.

Sticky flags:
- clr_err clears ovf and unf.
- A new error in the same cycle as clr_err wins: that flag ends at 1.

Reset (reset = 0 at a rising edge):
- count = 0, ovf = 0, unf = 0.
- Array contents need not be cleared; top_* still read 0 because empty gates them.
- Reset during any operation overrides all inputs in that cycle.

Width rules:
- pc_in and flags_in are stored verbatim. No arithmetic is performed on stored values.
- count never wraps: it saturates logically at 0 and DEPTH through the error rules above.

## Timing
- All state updates happen on the rising edge of clk; there are no multicycle paths.
- Push latency 1: the value pushed at edge N appears on top_pc/top_flags/top_is_int and in count after edge N.
- Pop latency 1: after the popping edge, top_* show the previous entry, or 0 if now empty.
- top_* are valid combinationally in the same cycle as a pop request. The CPU's stack mux can therefore load top_pc into the PC on the same edge that pops, as in a single-cycle return.
- ovf/unf assert the cycle after the offending edge and hold until clr_err or reset.
- Reset values: top_pc = 0, top_flags = 0, top_is_int = 0, count = 0, empty = 1, full = 0, ovf = 0, unf = 0.

## Test plan
- Reset then fill: after reset, check count = 0, empty = 1. With DEPTH = 4 and AW = 10, push pc_in = 0x010, 0x020, 0x030, 0x040 on consecutive cycles. Required: count = 4, full = 1, top_pc = 0x040, top_is_int = 0, ovf = 0.
- Overflow and clear: from full, push pc_in = 0x3FF. Required: top_pc stays 0x040, count = 4, ovf = 1. Then clr_err alone → ovf = 0. Then clr_err together with another full push → ovf = 1.
- Interrupt frame: push_int with pc_in = 0x155, flags_in = 2'b10, with push also asserted. Required: top_pc = 0x155, top_flags = 2'b10, top_is_int = 1. Then pop → top returns to the prior call frame with top_flags = 0.
- Underflow: pop from empty. Required: count = 0, top_pc = 0, unf = 1. Then push and pop together while empty → count = 1, top_pc = pc_in, unf = 1.
- Replace top: with count = 2 and top 0x020, assert push and pop with pc_in = 0x2AA. Required: count = 2, top_pc = 0x2AA. Then pop → top_pc = 0x010. Repeat while full → ovf stays 0.
- Reset mid-operation: assert reset = 0 in the same cycle as push with count = 3, ovf = 1. Required next cycle: count = 0, empty = 1, ovf = 0, unf = 0, top_pc = 0.
